// File: rtl/slicer_axil_regs.sv
// slicer_axil_regs: AXI4-Lite slave holding four byte-strobed configuration registers for the slicer core
module slicer_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_out
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {W_INIT, W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} rstate_t;

  wstate_t         wstate_q, wstate_d;
  rstate_t         rstate_q, rstate_d;
  logic            started_q;
  logic [1:0]      awidx_q, awidx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic            arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   regs_q [4];
  logic [DW-1:0]   regs_d [4];
  logic            commit;
  logic [1:0]      cidx;
  logic [DW-1:0]   cdata;
  logic [SW-1:0]   cstrb;
  logic            aw_hs, w_hs, ar_hs;
  logic            unused_ok;

  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign reg0_out      = regs_q[0];
  assign reg1_out      = regs_q[1];
  assign reg2_out      = regs_q[2];
  assign reg3_out      = regs_q[3];
  assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // write channel: collect AW and W in either order, pick the commit source, hold the response
  always_comb begin
    wstate_d = wstate_q;
    awidx_d  = awidx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    commit   = 1'b0;
    cidx     = S_AXI_AWADDR[3:2];
    cdata    = S_AXI_WDATA;
    cstrb    = S_AXI_WSTRB;
    case (wstate_q)
      W_INIT: wstate_d = started_q ? W_IDLE : W_INIT;
      W_IDLE: begin
        commit = aw_hs && w_hs;
        if (commit) wstate_d = W_RESP;
        else if (aw_hs) begin
          wstate_d = W_HAVE_AW;
          awidx_d  = S_AXI_AWADDR[3:2];
        end else if (w_hs) begin
          wstate_d = W_HAVE_W;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
      end
      W_HAVE_AW: begin
        commit   = w_hs;
        cidx     = awidx_q;
        wstate_d = w_hs ? W_RESP : W_HAVE_AW;
      end
      W_HAVE_W: begin
        commit   = aw_hs;
        cdata    = wdata_q;
        cstrb    = wstrb_q;
        wstate_d = aw_hs ? W_RESP : W_HAVE_W;
      end
      W_RESP: wstate_d = S_AXI_BREADY ? W_IDLE : W_RESP;
      default: wstate_d = W_INIT;
    endcase
    awready_d = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_W);
    wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_AW);
    bvalid_d  = wstate_d == W_RESP;
  end

  // register file: merge the strobed lanes of a committing write into the selected register
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
      for (int b = 0; b < SW; b++)
        if (commit && cidx == 2'(i) && cstrb[b]) regs_d[i][8*b +: 8] = cdata[8*b +: 8];
    end
  end

  // read channel: capture the pre-write register value on AR and hold it until R completes
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_INIT: rstate_d = started_q ? R_IDLE : R_INIT;
      R_IDLE: if (ar_hs) begin
        rstate_d = R_DATA;
        rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
      end
      R_DATA: rstate_d = S_AXI_RREADY ? R_IDLE : R_DATA;
      default: rstate_d = R_INIT;
    endcase
    arready_d = rstate_d == R_IDLE;
    rvalid_d  = rstate_d == R_DATA;
  end

  // state and output flops; ready outputs come up two edges after reset is released
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wstate_q  <= W_INIT;
      rstate_q  <= R_INIT;
      started_q <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      started_q <= 1'b1;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end
endmodule

// File: tb/tb_slicer_axil_regs.sv
// tb_slicer_axil_regs: randomized and directed AXI4-Lite traffic checked against a register-array model
module tb_slicer_axil_regs;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0]    awprot = '0, arprot = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata, reg0_out, reg1_out, reg2_out, reg3_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  slicer_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out), .reg3_out(reg3_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_r0"}, reg0_out, model[0]);
    check({tag, "_r1"}, reg1_out, model[1]);
    check({tag, "_r2"}, reg2_out, model[2]);
    check({tag, "_r3"}, reg3_out, model[3]);
  endtask

  task automatic send_aw(input logic [AW-1:0] a, input int d);
    int n = 0;
    repeat (d) tick();
    awaddr = a;
    awvalid = 1'b1;
    while (!awready && n < 50) begin tick(); n++; end
    if (!awready) check("aw_timeout", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] v, input logic [3:0] s, input int d);
    int n = 0;
    repeat (d) tick();
    wdata = v;
    wstrb = s;
    wvalid = 1'b1;
    while (!wready && n < 50) begin tick(); n++; end
    if (!wready) check("w_timeout", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic get_b(input int bd);
    int n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    check("bvalid", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'd0);
    repeat (bd) begin
      tick();
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("awready_bp", 32'(awready), 32'd0);
      check("wready_bp", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [31:0] v, input logic [3:0] s,
                       input int awd, input int wd, input int bd);
    fork
      send_aw(a, awd);
      send_w(v, s, wd);
    join
    for (int b = 0; b < 4; b++) if (s[b]) model[a[3:2]][8*b +: 8] = v[8*b +: 8];
    check_regs("wr");
    get_b(bd);
  endtask

  task automatic read(input logic [AW-1:0] a, input int rd, output logic [31:0] v);
    int n = 0;
    logic [31:0] d0;
    araddr = a;
    arvalid = 1'b1;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) check("ar_timeout", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    check("rvalid", 32'(rvalid), 32'd1);
    check("rresp", 32'(rresp), 32'd0);
    d0 = rdata;
    repeat (rd) begin
      tick();
      check("rdata_hold", rdata, d0);
      check("arready_bp", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_drop", 32'(rvalid), 32'd0);
    v = d0;
  endtask

  task automatic basic();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) write(AW'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      read(AW'(i * 4), 0, v);
      check("basic_rd", v, 32'(i + 1));
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", 32'({bresp, rresp}), 32'd0);
    for (int i = 0; i < 4; i++) model[i] = '0;
    check_regs("rst");
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    tick();
    check("ready_wait", 32'({awready, wready, arready}), 32'd0);
    tick();
    check("ready_up", 32'({awready, wready, arready}), 32'd7);
  endtask

  initial begin
    logic [31:0] v;
    logic [AW-1:0] a;
    repeat (3) tick();
    check_reset_outputs();
    release_reset();
    basic();

    write(AW'(4), 32'hAABBCCDD, 4'hF, 0, 0, 0);
    write(AW'(4), 32'h11223344, 4'h5, 0, 0, 0);
    check("strobe_5", reg1_out, 32'hAA22CC44);
    write(AW'(4), 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    check("strobe_0", reg1_out, 32'hAA22CC44);

    fork
      send_w(32'hDEADBEEF, 4'hF, 0);
      send_aw(AW'(8), 3);
      begin
        tick();
        check("wready_after_w", 32'(wready), 32'd0);
        check("awready_have_w", 32'(awready), 32'd1);
      end
    join
    model[2] = 32'hDEADBEEF;
    check("w_first_commit", reg2_out, 32'hDEADBEEF);
    get_b(0);

    fork
      send_aw(AW'(0), 0);
      send_w(32'h12345678, 4'hF, 0);
    join
    model[0] = 32'h12345678;
    awaddr = AW'(0);
    wdata = 32'h87654321;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    repeat (5) begin
      tick();
      check("bp_bvalid", 32'(bvalid), 32'd1);
      check("bp_ready", 32'({awready, wready}), 32'd0);
      check("bp_reg0", reg0_out, 32'h12345678);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b0;
    model[0] = 32'h87654321;
    check("bp_second", reg0_out, 32'h87654321);
    get_b(0);

    read(AW'(0), 4, v);
    check("rd_bp", v, 32'h87654321);

    write(AW'(6'h10), 32'h5A5A5A5A, 4'hF, 0, 0, 0);
    check("alias_wr", reg0_out, 32'h5A5A5A5A);
    read(AW'(6'h31), 0, v);
    check("alias_rd", v, 32'h5A5A5A5A);

    fork
      write(AW'(6'h0C), 32'h9, 4'hF, 0, 0, 0);
      read(AW'(6'h0C), 0, v);
    join
    check("collide_old", v, 32'h4);
    read(AW'(6'h0C), 0, v);
    check("collide_new", v, 32'h9);

    repeat (60) begin
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 1)
        write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else begin
        read(a, $urandom_range(0, 2), v);
        check("rand_rd", v, model[a[3:2]]);
      end
    end

    fork
      send_aw(AW'(4), 0);
      send_w(32'hCAFEF00D, 4'hF, 0);
    join
    check("mid_bvalid", 32'(bvalid), 32'd1);
    awaddr = AW'(8);
    awvalid = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    awvalid = 1'b0;
    check_reset_outputs();
    release_reset();
    basic();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/slicer_axil_regs.md
# slicer_axil_regs

AXI4-Lite slave register file for the slicer IP, sitting directly downstream of the S00_AXI bus master. It holds four 32-bit software-visible configuration registers, supports byte-strobed writes and read-back, and exports the register contents to the slicer datapath. Read and write channels are independent. Every handshake output is driven from flops.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.

- S_AXI_ACLK  in  1  single clock; all logic on the rising edge.
- S_AXI_ARESETN  in  1  reset, synchronous, active-low.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit k covers WDATA[8k+7:8k].
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- reg0_out..reg3_out  out  32 each  current register contents, to the slicer core.

## Operation
- A handshake occurs at a rising edge when VALID and READY are both high.
- Address decode:
  - Index is ADDR[3:2]. Offsets 0x0, 0x4, 0x8 and 0xC map to reg0..reg3.
  - Bits [1:0] are ignored, and any higher bits alias.
- Write path states:
  - IDLE: AWREADY=1, WREADY=1.
  - HAVE_AW: AW held; AWREADY=0, WREADY=1.
  - HAVE_W: W held; AWREADY=1, WREADY=0.
  - RESP: BVALID=1, AWREADY=0, WREADY=0.
- Write transitions:
  - AW only handshakes → HAVE_AW.
  - W only handshakes → HAVE_W.
  - Both handshake in the same edge, or the missing half arrives in HAVE_AW/HAVE_W → commit, then RESP.
  - RESP → IDLE on the B handshake.
- Commit: at the commit edge, each byte lane with WSTRB set is loaded into the selected register. Lanes with WSTRB clear keep their value. WSTRB=0 is still a legal write with an OKAY response.
- Read path states:
  - R_IDLE: ARREADY=1, RVALID=0.
  - R_DATA: ARREADY=0, RVALID=1.
- Read transitions:
  - An AR handshake loads RDATA with the addressed register → R_DATA.
  - The R handshake → R_IDLE.
  - RDATA is held stable while RVALID=1 and RREADY=0.
- Simultaneous read and write commit to the same register on one edge: the read returns the pre-write value.
- reg*_out are direct register flops.

## Timing
- Reset: when S_AXI_ARESETN is sampled low, at that edge:
  - all registers → 0;
  - AWREADY, WREADY, ARREADY, BVALID, RVALID → 0;
  - RDATA → 0; BRESP and RRESP → 0;
  - any held AW or W is discarded.
- First cycle after reset is sampled high: outputs stay at reset values. The ready outputs rise after the following edge (IDLE / R_IDLE).
- Write latency:
  - The commit edge updates reg*_out and raises BVALID for the next cycle.
  - Minimum spacing between write handshakes is 2 cycles with BREADY tied high.
- Read latency:
  - RVALID is high the cycle after the AR handshake.
  - Back-to-back reads take 2 cycles each.
- Backpressure:
  - While BVALID=1 and BREADY=0: no new AW or W is accepted and the registers are unchanged.
  - While RVALID=1 and RREADY=0: ARREADY=0.
- No combinational path from any input to any output.

## Test plan
- Basic write and read-back:
  - After reset, write 0x1, 0x2, 0x3, 0x4 to offsets 0x0, 0x4, 0x8, 0xC with WSTRB=0xF.
  - Every BRESP=OKAY and reg0_out..reg3_out = 1, 2, 3, 4.
  - Reads of the same offsets return 1, 2, 3, 4 with RRESP=OKAY.
- Byte strobes:
  - reg1=0xAABBCCDD, then write 0x11223344 with WSTRB=0x5 → reg1_out=0xAA22CC44.
  - Then write WSTRB=0 → reg1 unchanged and BVALID still asserted.
- Channel ordering: W is presented 3 cycles before AW (addr 0x8, data 0xDEADBEEF).
  - WREADY handshakes first and WREADY is then 0.
  - The AW handshake commits; reg2_out=0xDEADBEEF the next cycle.
- Backpressure:
  - Hold BREADY=0 for 5 cycles after a write. BVALID stays high, AWREADY and WREADY stay 0, and a second write issued meanwhile only completes after the B handshake.
  - Same check with RREADY=0: RDATA is stable.
- Aliasing and collision:
  - Write 0x5A5A5A5A to 0x10 → reg0 updated.
  - A same-edge read of reg3 during a commit to reg3 (old 0x4, new 0x9) returns 0x4; a subsequent read returns 0x9.
- Reset mid-operation:
  - Assert reset with BVALID pending and an AW held. Next cycle all outputs are 0 and reg0..reg3=0.
  - After release, the basic write/read-back sequence passes.
